// File: rtl/morse_letter_receiver.sv
// Morse letter receiver: times key marks and spaces in ticks, builds a
// left-justified dot/dash pattern and decodes it into one of A..H.
// Outputs symbol/size/letter are registered and hold until the next valid.
// valid and error are single-cycle pulses and never coincide.
// o_dbg_state exposes the FSM state encoding for external checkers.
module morse_letter_receiver #(
  parameter int DOT_MAX   = 2,
  parameter int DASH_MAX  = 6,
  parameter int GAP_TICKS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       key_in,
  output logic [3:0] symbol,
  output logic [2:0] size,
  output logic [2:0] letter,
  output logic       valid,
  output logic       error,
  output logic       busy,
  output logic [1:0] o_dbg_state
);

  localparam int MW = $clog2(DASH_MAX + 2);
  localparam int SW = $clog2(GAP_TICKS + 1);
  localparam logic [MW-1:0] DOT_L  = MW'(DOT_MAX);
  localparam logic [MW-1:0] DASH_L = MW'(DASH_MAX);
  localparam logic [SW-1:0] GAP_M1 = SW'(GAP_TICKS - 1);

  typedef enum logic [1:0] {S_IDLE, S_MARK, S_SPACE, S_DRAIN} state_t;

  state_t        r_state, w_state_next;
  logic          r_sync1, r_sync2;
  logic [MW-1:0] r_mark_cnt, w_mark_next;
  logic [SW-1:0] r_space_cnt, w_space_next;
  logic [2:0]    r_elem_cnt, w_elem_next;
  logic [3:0]    r_shift, w_shift_next;
  logic [3:0]    r_symbol, w_symbol_next;
  logic [2:0]    r_size, w_size_next;
  logic [2:0]    r_letter, w_letter_next;
  logic          r_valid, w_valid_next;
  logic          r_error, w_error_next;
  logic          w_key_s;
  logic          w_match;
  logic [2:0]    w_dec_letter;

  assign w_key_s     = r_sync2;
  assign symbol      = r_symbol;
  assign size        = r_size;
  assign letter      = r_letter;
  assign valid       = r_valid;
  assign error       = r_error;
  assign busy        = (r_state != S_IDLE);
  assign o_dbg_state = r_state;

  // Two-flop synchronizer for the asynchronous key input.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= key_in;
      r_sync2 <= r_sync1;
    end
  end

  // Letter lookup on the accumulated (count, left-justified pattern) pair.
  always_comb begin
    w_match      = 1'b1;
    w_dec_letter = 3'd0;
    case ({r_elem_cnt, r_shift})
      7'b010_0100: w_dec_letter = 3'd0;  // A .-
      7'b100_1000: w_dec_letter = 3'd1;  // B -...
      7'b100_1010: w_dec_letter = 3'd2;  // C -.-.
      7'b011_1000: w_dec_letter = 3'd3;  // D -..
      7'b001_0000: w_dec_letter = 3'd4;  // E .
      7'b100_0010: w_dec_letter = 3'd5;  // F ..-.
      7'b011_1100: w_dec_letter = 3'd6;  // G --.
      7'b100_0000: w_dec_letter = 3'd7;  // H ....
      default:     w_match      = 1'b0;
    endcase
  end

  // Next-state and datapath: key edges are handled before the tick, and a
  // tick arriving with an edge is counted into the new state's counter.
  always_comb begin
    w_state_next  = r_state;
    w_mark_next   = r_mark_cnt;
    w_space_next  = r_space_cnt;
    w_elem_next   = r_elem_cnt;
    w_shift_next  = r_shift;
    w_symbol_next = r_symbol;
    w_size_next   = r_size;
    w_letter_next = r_letter;
    w_valid_next  = 1'b0;
    w_error_next  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_key_s) begin
          w_state_next = S_MARK;
          w_mark_next  = MW'(tick);
          w_elem_next  = 3'd0;
          w_shift_next = 4'd0;
        end
      end
      S_MARK: begin
        if (!w_key_s) begin
          w_space_next = SW'(tick);
          if (r_mark_cnt == '0) begin
            // Sub-tick pulse: ignored, no element recorded.
            w_state_next = (r_elem_cnt != 3'd0) ? S_SPACE : S_IDLE;
          end else if (r_elem_cnt == 3'd4) begin
            w_error_next = 1'b1;
            w_state_next = S_DRAIN;
          end else begin
            w_shift_next[2'd3 - r_elem_cnt[1:0]] = (r_mark_cnt > DOT_L);
            w_elem_next  = r_elem_cnt + 3'd1;
            w_state_next = S_SPACE;
          end
        end else if (tick) begin
          if (r_mark_cnt == DASH_L) begin
            w_mark_next  = DASH_L + MW'(1);
            w_error_next = 1'b1;
            w_space_next = '0;
            w_state_next = S_DRAIN;
          end else begin
            w_mark_next = r_mark_cnt + MW'(1);
          end
        end
      end
      S_SPACE: begin
        if (w_key_s) begin
          w_state_next = S_MARK;
          w_mark_next  = MW'(tick);
        end else if (tick) begin
          if (r_space_cnt >= GAP_M1) begin
            w_state_next = S_IDLE;
            if (w_match) begin
              w_valid_next  = 1'b1;
              w_symbol_next = r_shift;
              w_size_next   = r_elem_cnt;
              w_letter_next = w_dec_letter;
            end else begin
              w_error_next = 1'b1;
            end
          end else begin
            w_space_next = r_space_cnt + SW'(1);
          end
        end
      end
      S_DRAIN: begin
        // Any mark restarts the quiet-gap wait.
        if (w_key_s) begin
          w_space_next = '0;
        end else if (tick) begin
          if (r_space_cnt >= GAP_M1) begin
            w_state_next = S_IDLE;
          end else begin
            w_space_next = r_space_cnt + SW'(1);
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State, counters, accumulator and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_mark_cnt  <= '0;
      r_space_cnt <= '0;
      r_elem_cnt  <= 3'd0;
      r_shift     <= 4'd0;
      r_symbol    <= 4'd0;
      r_size      <= 3'd0;
      r_letter    <= 3'd0;
      r_valid     <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_mark_cnt  <= w_mark_next;
      r_space_cnt <= w_space_next;
      r_elem_cnt  <= w_elem_next;
      r_shift     <= w_shift_next;
      r_symbol    <= w_symbol_next;
      r_size      <= w_size_next;
      r_letter    <= w_letter_next;
      r_valid     <= w_valid_next;
      r_error     <= w_error_next;
    end
  end

endmodule

// File: tb/tb_morse_letter_receiver.sv
// Testbench for morse_letter_receiver: directed letters, malformed letters,
// reset mid-letter, then random letters scored against a pattern-level model.
module tb_morse_letter_receiver;

  localparam int DOT_MAX   = 2;
  localparam int DASH_MAX  = 6;
  localparam int GAP_TICKS = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       key_in = 1'b0;
  logic [3:0] symbol;
  logic [2:0] size;
  logic [2:0] letter;
  logic       valid;
  logic       error;
  logic       busy;
  logic [1:0] dbg_state;

  int checks = 0;
  int failures = 0;

  // Expected pulse entry: {is_valid, symbol, size, letter}
  logic [10:0] exp_q[$];
  int          seq_q[$];
  logic [3:0]  held_sym = 4'd0;
  logic [2:0]  held_size = 3'd0;
  logic [2:0]  held_letter = 3'd0;
  logic [3:0]  tbl_sym[8];
  int          tbl_size[8];

  morse_letter_receiver #(
    .DOT_MAX(DOT_MAX), .DASH_MAX(DASH_MAX), .GAP_TICKS(GAP_TICKS)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .key_in(key_in),
    .symbol(symbol), .size(size), .letter(letter),
    .valid(valid), .error(error), .busy(busy), .o_dbg_state(dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One tick period: 8 clocks, tick high for one clock in the middle so key
  // changes at period boundaries are well clear of the tick.
  task automatic tick_period();
    repeat (4) @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    key_in = 1'b0;
    tick = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    held_sym = 4'd0;
    held_size = 3'd0;
    held_letter = 3'd0;
  endtask

  // Reference model: classifies each mark length, applies the 4-element and
  // overlong limits, and looks the pattern up in the letter table.
  function automatic void model_push();
    logic [3:0] pat;
    int n;
    bit err;
    bit found;
    pat = 4'd0;
    n = 0;
    err = 1'b0;
    found = 1'b0;
    foreach (seq_q[i]) begin
      if (!err) begin
        if (seq_q[i] > DASH_MAX) err = 1'b1;
        else if (n == 4) err = 1'b1;
        else begin
          if (seq_q[i] > DOT_MAX) pat[3 - n] = 1'b1;
          n++;
        end
      end
    end
    if (!err) begin
      for (int k = 0; k < 8; k++) begin
        if (!found && tbl_size[k] == n && tbl_sym[k] == pat) begin
          found = 1'b1;
          held_sym = pat;
          held_size = 3'(n);
          held_letter = 3'(k);
        end
      end
    end
    exp_q.push_back({found, held_sym, held_size, held_letter});
  endfunction

  // Driver: marks of seq_q lengths separated by 1-tick spaces, then a gap.
  task automatic send_letter(input string tag);
    model_push();
    foreach (seq_q[i]) begin
      key_in = 1'b1;
      repeat (seq_q[i]) tick_period();
      key_in = 1'b0;
      if (i != seq_q.size() - 1) tick_period();
    end
    repeat (GAP_TICKS) tick_period();
    repeat (2) @(negedge clk);
    check_val({tag, "_pending"}, exp_q.size(), 0);
    check_val({tag, "_busy_idle"}, busy, 1'b0);
  endtask

  // Scoreboard monitor: every pulse must match the head of the queue.
  initial begin
    logic [10:0] e;
    forever begin
      @(negedge clk);
      if (reset && (valid || error)) begin
        check_val("valid_and_error", valid & error, 1'b0);
        if (exp_q.size() == 0) begin
          check_val("unexpected_pulse", {valid, error}, 2'b00);
        end else begin
          e = exp_q.pop_front();
          check_val("pulse_kind", valid, e[10]);
          check_val("symbol", symbol, e[9:6]);
          check_val("size", size, e[5:3]);
          check_val("letter", letter, e[2:0]);
        end
      end
    end
  end

  initial begin
    int idx;
    int n;
    tbl_sym = '{4'b0100, 4'b1000, 4'b1010, 4'b1000, 4'b0000, 4'b0010, 4'b1100, 4'b0000};
    tbl_size = '{2, 4, 4, 3, 1, 4, 3, 4};

    do_reset();
    check_val("rst_symbol", symbol, 4'd0);
    check_val("rst_size", size, 3'd0);
    check_val("rst_letter", letter, 3'd0);
    check_val("rst_valid", valid, 1'b0);
    check_val("rst_error", error, 1'b0);
    check_val("rst_busy", busy, 1'b0);

    // A: dot, dash
    seq_q = '{1, 4};
    send_letter("letter_a");
    // C: dash dot dash dot
    seq_q = '{4, 1, 4, 1};
    send_letter("letter_c");

    // Overlong mark: error on the 7th tick, busy until release plus gap.
    seq_q = '{7};
    model_push();
    key_in = 1'b1;
    repeat (7) tick_period();
    check_val("long_err_seen", exp_q.size(), 0);
    check_val("long_busy_held", busy, 1'b1);
    key_in = 1'b0;
    repeat (GAP_TICKS - 1) tick_period();
    check_val("long_busy_drain", busy, 1'b1);
    tick_period();
    check_val("long_busy_done", busy, 1'b0);
    check_val("long_hold_letter", letter, 3'd2);

    // Five dots: error on the fifth release.
    seq_q = '{1, 1, 1, 1, 1};
    send_letter("five_dots");
    // Dash-dash-dash is not in the table: error, outputs hold.
    seq_q = '{4, 4, 4};
    send_letter("no_match");
    check_val("hold_symbol", symbol, 4'b1010);
    check_val("hold_size", size, 3'd4);

    // Reset after two elements of H discards the partial letter.
    for (int i = 0; i < 2; i++) begin
      key_in = 1'b1;
      tick_period();
      key_in = 1'b0;
      tick_period();
    end
    check_val("mid_busy", busy, 1'b1);
    do_reset();
    check_val("mid_rst_symbol", symbol, 4'd0);
    check_val("mid_rst_size", size, 3'd0);
    check_val("mid_rst_letter", letter, 3'd0);
    check_val("mid_rst_busy", busy, 1'b0);
    seq_q = '{1};
    send_letter("letter_e");
    check_val("e_size", size, 3'd1);
    check_val("e_letter", letter, 3'd4);

    // Random letters: mostly legal table entries, some arbitrary sequences.
    for (int t = 0; t < 40; t++) begin
      seq_q.delete();
      if ($urandom_range(0, 9) < 7) begin
        idx = $urandom_range(0, 7);
        for (int j = 0; j < tbl_size[idx]; j++) begin
          if (tbl_sym[idx][3 - j]) seq_q.push_back($urandom_range(DOT_MAX + 1, DASH_MAX));
          else seq_q.push_back($urandom_range(1, DOT_MAX));
        end
      end else begin
        n = $urandom_range(1, 5);
        for (int j = 0; j < n; j++) begin
          if ($urandom_range(0, 9) == 0) seq_q.push_back(DASH_MAX + 1);
          else seq_q.push_back($urandom_range(1, DASH_MAX));
        end
      end
      send_letter("rand");
    end

    repeat (10) @(negedge clk);
    check_val("final_pending", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
